// File: rtl/pjesetuesi_16.sv
// rtl/pjesetuesi_16.sv - sequential restoring unsigned divider, one quotient bit per clock
module pjesetuesi_16 #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV0
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;
    logic             div0;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // A restored remainder is always below the divisor, so r needs only WIDTH
    // bits between iterations; the extra bit lives only in shifted/diff.
    always_comb begin
        shifted    = {r, q[WIDTH-1]};
        diff       = shifted - {1'b0, dvsr};
        state_next = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = (DIVISOR == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dvsr  <= '0;
            cnt   <= '0;
            div0  <= 1'b0;
        end else begin
            state <= state_next;
            BUSY  <= (state_next == RUN);
            DONE  <= (state_next == FIN);
            case (state)
                IDLE: begin
                    if (START) begin
                        if (DIVISOR != '0) begin
                            q    <= DIVIDEND;
                            dvsr <= DIVISOR;
                            r    <= '0;
                            cnt  <= '0;
                            div0 <= 1'b0;
                        end else begin
                            q    <= '1;
                            r    <= DIVIDEND;
                            div0 <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (!diff[WIDTH]) begin
                        r <= diff[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        r <= shifted[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign QUOTIENT  = q;
    assign REMAINDER = r;
    assign DIV0      = div0;

endmodule

// File: tb/tb_pjesetuesi_16.sv
// tb/tb_pjesetuesi_16.sv - directed and random self-checking bench for pjesetuesi_16
module tb_pjesetuesi_16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] DIVIDEND = '0;
    logic [15:0] DIVISOR = '0;
    logic        BUSY;
    logic        DONE;
    logic [15:0] QUOTIENT;
    logic [15:0] REMAINDER;
    logic        DIV0;

    int checks = 0;
    int errors = 0;

    pjesetuesi_16 #(.WIDTH(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .DIVIDEND (DIVIDEND),
        .DIVISOR  (DIVISOR),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .QUOTIENT (QUOTIENT),
        .REMAINDER(REMAINDER),
        .DIV0     (DIV0)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge right after the accepting edge E0.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge CLK);
        START    = 1'b1;
        DIVIDEND = a;
        DIVISOR  = b;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!DONE && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("done_timeout", {31'd0, DONE}, 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b);
        int          n;
        logic [15:0] eq;
        logic [15:0] er;
        start_op(a, b);
        wait_done(n);
        if (b == 16'd0) begin
            eq = 16'hFFFF;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
        chk({tag, "_q"}, {16'd0, QUOTIENT}, {16'd0, eq});
        chk({tag, "_r"}, {16'd0, REMAINDER}, {16'd0, er});
        chk({tag, "_div0"}, {31'd0, DIV0}, {31'd0, (b == 16'd0)});
        @(negedge CLK);
    endtask

    initial begin
        int n;
        int busy_cnt;
        int bad;
        logic [15:0] a;
        logic [15:0] b;

        // reset and idle
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (BUSY !== 1'b0 || DONE !== 1'b0 || DIV0 !== 1'b0 ||
                QUOTIENT !== 16'd0 || REMAINDER !== 16'd0) bad++;
        end
        chk("reset_idle", bad, 0);

        // 100 / 7 with exact latency
        start_op(16'd100, 16'd7);
        busy_cnt = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (BUSY === 1'b1) busy_cnt++;
            if (DONE !== 1'b0) bad++;
            @(negedge CLK);
        end
        chk("busy_cycles", busy_cnt, 16);
        chk("no_early_done", bad, 0);
        chk("done_at_e16", {31'd0, DONE}, 32'd1);
        chk("busy_low_at_done", {31'd0, BUSY}, 32'd0);
        chk("q_100_7", {16'd0, QUOTIENT}, 32'd14);
        chk("r_100_7", {16'd0, REMAINDER}, 32'd2);
        chk("div0_100_7", {31'd0, DIV0}, 32'd0);
        @(negedge CLK);
        chk("done_one_cycle", {31'd0, DONE}, 32'd0);

        // boundary operands
        run_check("ffff_1", 16'hFFFF, 16'd1);
        run_check("3_10", 16'd3, 16'd10);
        run_check("ffff_ffff", 16'hFFFF, 16'hFFFF);

        // divide by zero
        start_op(16'd5, 16'd0);
        chk("dz_done", {31'd0, DONE}, 32'd1);
        chk("dz_busy", {31'd0, BUSY}, 32'd0);
        chk("dz_q", {16'd0, QUOTIENT}, 32'hFFFF);
        chk("dz_r", {16'd0, REMAINDER}, 32'd5);
        chk("dz_div0", {31'd0, DIV0}, 32'd1);
        @(negedge CLK);
        chk("dz_done_pulse", {30'd0, DONE, BUSY}, 32'd0);

        // START during RUN is ignored
        start_op(16'd1000, 16'd3);
        repeat (4) @(negedge CLK);
        START    = 1'b1;
        DIVIDEND = 16'd9;
        DIVISOR  = 16'd2;
        @(negedge CLK);
        START = 1'b0;
        wait_done(n);
        chk("ign_q", {16'd0, QUOTIENT}, 32'd333);
        chk("ign_r", {16'd0, REMAINDER}, 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        chk("ign_no_second_op", bad, 0);

        // back-to-back, second START held from the DONE cycle
        start_op(16'd1000, 16'd3);
        wait_done(n);
        chk("b2b_q1", {16'd0, QUOTIENT}, 32'd333);
        chk("b2b_r1", {16'd0, REMAINDER}, 32'd1);
        START    = 1'b1;
        DIVIDEND = 16'd9;
        DIVISOR  = 16'd2;
        @(negedge CLK);
        @(negedge CLK);
        START = 1'b0;
        wait_done(n);
        chk("b2b_spacing", n + 2, 18);
        chk("b2b_q2", {16'd0, QUOTIENT}, 32'd4);
        chk("b2b_r2", {16'd0, REMAINDER}, 32'd1);
        @(negedge CLK);

        // reset mid-run
        start_op(16'd100, 16'd7);
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_outputs", {12'd0, BUSY, DONE, DIV0, 1'b0, QUOTIENT}, 32'd0);
        chk("rst_rem", {16'd0, REMAINDER}, 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        chk("rst_no_done", bad, 0);
        run_check("after_rst", 16'd100, 16'd7);

        // random operands against the / and % reference
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(0, 15));
                default: b = 16'($urandom);
            endcase
            run_check("rand", a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
